sccb_target: RTL



---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_bit_sync.sv | 42 ++++
 rtl/sccb_target.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-bank target: FSM encodings,
// the read/write bit position in the device ID, and counter sizing.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ACK_ID,
        ST_SUB,
        ST_ACK_SUB,
        ST_DATA,
        ST_ACK_DATA,
        ST_RD,
        ST_RD_NA,
        ST_IGNORE
    } sccb_state_t;

    localparam int          SCCB_RD_BIT    = 0;
    localparam logic [7:0]  SCCB_DEF_DEV_ID = 8'h42;
    localparam int          SCCB_BIT_CNT_W = 4;

endpackage

// File: rtl/sccb_bit_sync.sv
// Two-flop synchroniser for the SCCB pins plus edge and START/STOP detection
// on the synchronised copies. Flops reset high to match an idle bus.
module sccb_bit_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sioc,
    input  logic siod,
    output logic sioc_s,
    output logic siod_s,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start_det,
    output logic stop_det
);

    logic sioc_m, siod_m, sioc_q, siod_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sioc_m <= 1'b1;
            siod_m <= 1'b1;
            sioc_s <= 1'b1;
            siod_s <= 1'b1;
            sioc_q <= 1'b1;
            siod_q <= 1'b1;
        end else begin
            sioc_m <= sioc;
            siod_m <= siod;
            sioc_s <= sioc_m;
            siod_s <= siod_m;
            sioc_q <= sioc_s;
            siod_q <= siod_s;
        end
    end

    assign sioc_rise = sioc_s & ~sioc_q;
    assign sioc_fall = ~sioc_s & sioc_q;
    // siod may only move with sioc steady high to count as START/STOP
    assign start_det = sioc_s & sioc_q & siod_q & ~siod_s;
    assign stop_det  = sioc_s & sioc_q & ~siod_q & siod_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB device end with a 256x8 register bank (OV7670 emulator).
// Define SCCB_READ_EN to accept 2-phase reads (ID = DEV_ID|1).
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID    = SCCB_DEF_DEV_ID,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sioc,
    inout  wire        siod,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    logic sioc_s, siod_s, sioc_rise, sioc_fall, start_det, stop_det;

    sccb_bit_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sioc      (sioc),
        .siod      (siod),
        .sioc_s    (sioc_s),
        .siod_s    (siod_s),
        .sioc_rise (sioc_rise),
        .sioc_fall (sioc_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    sccb_state_t               state;
    logic [6:0]                shift;
    logic [SCCB_BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]                ptr;
    logic                      drive_low;
    logic [7:0]                bank [256];
    logic [7:0]                rx_byte;
`ifdef SCCB_READ_EN
    localparam logic [7:0]     RD_ID = DEV_ID | 8'(1 << SCCB_RD_BIT);
    logic                      is_rd;
    logic [6:0]                rd_shift;
`endif

    assign rx_byte = {shift, siod_s};
    assign siod    = drive_low ? 1'b0 : 1'bz;
    assign rd_data = bank[rd_addr];
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            drive_low <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < 256; i++) bank[i] <= RESET_VAL;
`ifdef SCCB_READ_EN
            is_rd     <= 1'b0;
            rd_shift  <= '0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state     <= ST_ID;
                bit_cnt   <= '0;
                drive_low <= 1'b0;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                drive_low <= 1'b0;
            end else begin
                case (state)
                    ST_ID, ST_SUB, ST_DATA: begin
                        drive_low <= 1'b0;
                        if (sioc_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == ST_ID) begin
                                    if (rx_byte == DEV_ID) begin
                                        state <= ST_ACK_ID;
`ifdef SCCB_READ_EN
                                        is_rd <= 1'b0;
                                    end else if (rx_byte == RD_ID) begin
                                        state <= ST_ACK_ID;
                                        is_rd <= 1'b1;
`endif
                                    end else begin
                                        state <= ST_IGNORE;
                                    end
                                end else if (state == ST_SUB) begin
                                    ptr   <= rx_byte;
                                    state <= ST_ACK_SUB;
                                end else begin
                                    bank[ptr] <= rx_byte;
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= rx_byte;
                                    state     <= ST_ACK_DATA;
                                end
                            end
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the next one ends it
                    ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: begin
                        if (sioc_fall) begin
                            if (!drive_low) begin
                                drive_low <= 1'b1;
                            end else begin
                                drive_low <= 1'b0;
                                if (state == ST_ACK_ID) begin
`ifdef SCCB_READ_EN
                                    if (is_rd) begin
                                        state     <= ST_RD;
                                        rd_shift  <= bank[ptr][6:0];
                                        drive_low <= ~bank[ptr][7];
                                    end else begin
                                        state <= ST_SUB;
                                    end
`else
                                    state <= ST_SUB;
`endif
                                end else if (state == ST_ACK_SUB) begin
                                    state <= ST_DATA;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
`ifdef SCCB_READ_EN
                    ST_RD: begin
                        if (sioc_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (sioc_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt   <= '0;
                                drive_low <= 1'b0;
                                state     <= ST_RD_NA;
                            end else begin
                                drive_low <= ~rd_shift[6];
                                rd_shift  <= {rd_shift[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_NA: begin
                        drive_low <= 1'b0;
                        if (sioc_rise) state <= ST_IGNORE;
                    end
`endif
                    default: begin
                        drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
